booth_mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one sequential radix-2 Booth multiplier core (8x8 signed to 16-bit) among N_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the core's load and operand inputs for one load cycle plus 8 iteration cycles. It then captures the product and returns it, tagged with the requester ID, over a valid/ready response channel. It sits between the requesting datapath blocks and the multiplier core.

---
 rtl/booth_mul_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential radix-2 Booth multiplier core among N_REQ requesters.
// Optional: define BOOTH_ARB_ZERO_BYPASS_EN to answer zero-operand requests directly without running the core.
module booth_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [8*N_REQ-1:0]        req_x,
  input  logic [8*N_REQ-1:0]        req_y,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic signed [15:0]        rsp_z,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy,
  output logic                      mul_load,
  output logic signed [7:0]         mul_x,
  output logic signed [7:0]         mul_y,
  input  logic signed [15:0]        mul_z
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE} state_t;

  state_t                    state, state_nxt;
  logic [ID_W-1:0]           rr_ptr;
  logic [2:0]                cnt;
  logic [ID_W-1:0]           gnt;
  logic                      gnt_vld;
  logic signed [DATA_W-1:0]  gnt_x, gnt_y;
  logic                      zero_op;
  int                        arb_idx;

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
    if (id == ID_W'(N_REQ - 1)) return '0;
    return id + ID_W'(1);
  endfunction

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    arb_idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      arb_idx = int'(rr_ptr) + k;
      if (arb_idx >= N_REQ) arb_idx = arb_idx - N_REQ;
      if (req_valid[arb_idx]) begin
        gnt     = ID_W'(arb_idx);
        gnt_vld = 1'b1;
      end
    end
  end

  assign gnt_x = req_x[gnt*DATA_W +: DATA_W];
  assign gnt_y = req_y[gnt*DATA_W +: DATA_W];

`ifdef BOOTH_ARB_ZERO_BYPASS_EN
  assign zero_op = (gnt_x == '0) || (gnt_y == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign req_ready = (rst_n && state == IDLE && gnt_vld) ? (N_REQ'(1) << gnt) : '0;
  assign mul_load  = (state == LOAD);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = zero_op ? DONE : LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt == 3'd7) state_nxt = CAPT;
      CAPT:    state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands stay latched until the next accept since the core re-reads X every iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      mul_x  <= '0;
      mul_y  <= '0;
      rsp_z  <= '0;
      rsp_id <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            mul_x  <= gnt_x;
            mul_y  <= gnt_y;
            rsp_id <= gnt;
            if (zero_op) rsp_z <= '0;
          end
        end
        LOAD:    cnt <= '0;
        RUN:     cnt <= cnt + 3'd1;
        CAPT:    rsp_z <= mul_z;
        DONE:    if (rsp_ready) rr_ptr <= rr_next(rsp_id);
        default: ;
      endcase
    end
  end

endmodule
